// File: rtl/spi_slave_regs.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// spi_slave_regs : oversampled SPI mode-0 slave with a small register file
//                  (address 0 = read-only ID, others read/write)
// Rev 1.0
// ============================================================================
module spi_slave_regs #(
   parameter int                DATA_W    = 8,
   parameter int                NUM_REGS  = 4,
   parameter logic [DATA_W-1:0] ID_VALUE  = 8'hA5,
   parameter logic [DATA_W-1:0] REG_RESET = 8'h00
)(
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         sclk,
   input  logic                         cs,
   input  logic                         mosi,
   output logic                         miso,
   output logic [NUM_REGS*DATA_W-1:0]   reg_out,
   output logic                         wr_strobe,
   output logic [$clog2(NUM_REGS)-1:0]  wr_addr,
   output logic                         frame_done,
   output logic                         frame_err,
   output logic                         busy
);

   localparam int ADDR_W  = $clog2(NUM_REGS);
   localparam int CMD_W   = 8;
   localparam int FRAME_W = CMD_W + DATA_W;
   localparam int CNT_W   = $clog2(FRAME_W + 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_CMD     = 3'd1,
      S_DATA    = 3'd2,
      S_TAIL    = 3'd3,
      S_WAIT_CS = 3'd4
   } state_t;

   state_t              r_state;
   logic                r_sclk_s1, r_sclk_s2, r_sclk_prev;
   logic                r_cs_s1, r_cs_s2, r_cs_prev;
   logic                r_mosi_s1, r_mosi_s2;
   logic [1:0]          r_settle;
   logic [CNT_W-1:0]    r_bit_cnt;
   logic                r_is_write;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-2:0]   r_data_sr;
   logic [DATA_W-1:0]   r_tx_sr;
   logic [DATA_W-1:0]   r_regs [1:NUM_REGS-1];

   logic                w_sclk_rise, w_sclk_fall, w_cs_rise, w_cs_fall;
   logic [ADDR_W-1:0]   w_cmd_addr;
   logic [DATA_W-1:0]   w_data_word;
   logic [DATA_W-1:0]   w_rd_data;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sclk_s1   <= 1'b0;
         r_sclk_s2   <= 1'b0;
         r_sclk_prev <= 1'b0;
         r_cs_s1     <= 1'b1;
         r_cs_s2     <= 1'b1;
         r_cs_prev   <= 1'b1;
         r_mosi_s1   <= 1'b0;
         r_mosi_s2   <= 1'b0;
      end else begin
         r_sclk_s1   <= sclk;
         r_sclk_s2   <= r_sclk_s1;
         r_sclk_prev <= r_sclk_s2;
         r_cs_s1     <= cs;
         r_cs_s2     <= r_cs_s1;
         r_cs_prev   <= r_cs_s2;
         r_mosi_s1   <= mosi;
         r_mosi_s2   <= r_mosi_s1;
      end
   end

   assign w_sclk_rise = r_sclk_s2 & ~r_sclk_prev;
   assign w_sclk_fall = ~r_sclk_s2 & r_sclk_prev;
   assign w_cs_rise   = r_cs_s2 & ~r_cs_prev;
   assign w_cs_fall   = ~r_cs_s2 & r_cs_prev;

   // r_addr doubles as the command shift register, so on the 8th rise the
   // address is its low bits plus the bit arriving now.
   assign w_cmd_addr  = {r_addr[ADDR_W-2:0], r_mosi_s2};
   assign w_data_word = {r_data_sr, r_mosi_s2};

   always_comb begin
      w_rd_data = ID_VALUE;
      for (int i = 1; i < NUM_REGS; i++) begin
         if (w_cmd_addr == ADDR_W'(i)) w_rd_data = r_regs[i];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_WAIT_CS;
         r_settle   <= 2'd0;
         r_bit_cnt  <= '0;
         r_is_write <= 1'b0;
         r_addr     <= '0;
         r_data_sr  <= '0;
         r_tx_sr    <= '0;
         miso       <= 1'b0;
         wr_strobe  <= 1'b0;
         wr_addr    <= '0;
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
         busy       <= 1'b0;
         for (int i = 1; i < NUM_REGS; i++) r_regs[i] <= REG_RESET;
      end else begin
         wr_strobe  <= 1'b0;
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
         if (r_settle != 2'd3) r_settle <= r_settle + 2'd1;

         case (r_state)
            // Leave only once the synchronizers hold real pin values and cs is high.
            S_WAIT_CS: begin
               if (r_settle == 2'd3 && r_cs_s2) r_state <= S_IDLE;
            end
            S_IDLE: begin
               if (w_cs_fall) begin
                  r_state   <= S_CMD;
                  r_bit_cnt <= '0;
                  busy      <= 1'b1;
               end
            end
            S_CMD, S_DATA: begin
               if (w_cs_rise) begin
                  r_state   <= S_IDLE;
                  busy      <= 1'b0;
                  miso      <= 1'b0;
                  frame_err <= 1'b1;
               end else if (w_sclk_rise) begin
                  r_bit_cnt <= r_bit_cnt + 1'b1;
                  if (r_state == S_CMD) begin
                     r_addr <= w_cmd_addr;
                     if (r_bit_cnt == '0) r_is_write <= r_mosi_s2;
                     if (r_bit_cnt == CNT_W'(CMD_W - 1)) begin
                        r_state <= S_DATA;
                        r_tx_sr <= r_is_write ? '0 : w_rd_data;
                     end
                  end else begin
                     r_data_sr <= w_data_word[DATA_W-2:0];
                     if (r_bit_cnt == CNT_W'(FRAME_W - 1)) begin
                        r_state    <= S_TAIL;
                        busy       <= 1'b0;
                        miso       <= 1'b0;
                        frame_done <= 1'b1;
                        if (r_is_write && r_addr != '0) begin
                           wr_strobe <= 1'b1;
                           wr_addr   <= r_addr;
                           for (int i = 1; i < NUM_REGS; i++) begin
                              if (r_addr == ADDR_W'(i)) r_regs[i] <= w_data_word;
                           end
                        end
                     end
                  end
               end else if (w_sclk_fall && r_state == S_DATA) begin
                  miso    <= r_tx_sr[DATA_W-1];
                  r_tx_sr <= {r_tx_sr[DATA_W-2:0], 1'b0};
               end
            end
            S_TAIL: begin
               if (w_cs_rise) r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         reg_out[DATA_W-1:0] <= ID_VALUE;
         for (int i = 1; i < NUM_REGS; i++) reg_out[i*DATA_W +: DATA_W] <= REG_RESET;
      end else begin
         reg_out[DATA_W-1:0] <= ID_VALUE;
         for (int i = 1; i < NUM_REGS; i++) reg_out[i*DATA_W +: DATA_W] <= r_regs[i];
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_regs.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_spi_slave_regs : scoreboard bench driving SPI frames into spi_slave_regs
// Rev 1.0
// ============================================================================
module tb_spi_slave_regs;

   localparam int HALF = 50;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        sclk = 1'b0;
   logic        cs = 1'b1;
   logic        mosi = 1'b0;
   logic        miso;
   logic [31:0] reg_out;
   logic        wr_strobe;
   logic [1:0]  wr_addr;
   logic        frame_done;
   logic        frame_err;
   logic        busy;

   always #5 clk = ~clk;

   spi_slave_regs dut (
      .clk        (clk),
      .rst        (rst),
      .sclk       (sclk),
      .cs         (cs),
      .mosi       (mosi),
      .miso       (miso),
      .reg_out    (reg_out),
      .wr_strobe  (wr_strobe),
      .wr_addr    (wr_addr),
      .frame_done (frame_done),
      .frame_err  (frame_err),
      .busy       (busy)
   );

   // kind: 0 = write commit, 1 = frame done, 2 = frame error
   typedef struct {
      int          kind;
      logic [1:0]  addr;
      logic [7:0]  data;
      logic        is_read;
      logic [31:0] regs;
   } ev_t;

   ev_t         exp_q[$];
   ev_t         mon_e;
   logic [7:0]  model [4];
   logic [7:0]  last_rx;
   int          n_checks = 0;
   int          n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   function automatic logic [31:0] flat();
      return {model[3], model[2], model[1], model[0]};
   endfunction

   task automatic model_reset();
      model[0] = 8'hA5;
      for (int i = 1; i < 4; i++) model[i] = 8'h00;
   endtask

   task automatic push_ev(input int kind, input logic [1:0] a, input logic [7:0] d, input logic rd);
      ev_t e;
      e.kind = kind; e.addr = a; e.data = d; e.is_read = rd; e.regs = flat();
      exp_q.push_back(e);
   endtask

   // One master transaction; the model predicts its outcome before it is driven.
   task automatic frame(input logic [7:0] cmd, input logic [7:0] wd, input int nbits,
                        input bit raise_cs, input int gap_ns);
      logic [1:0] a;
      logic [7:0] rd_exp;
      a      = cmd[1:0];
      rd_exp = model[a];
      if (raise_cs) begin
         if (nbits >= 16) begin
            if (cmd[7] && a != 2'd0) begin
               model[a] = wd;
               push_ev(0, a, 8'h00, 1'b0);
            end
            push_ev(1, a, rd_exp, !cmd[7]);
         end else begin
            push_ev(2, a, 8'h00, 1'b0);
         end
      end
      last_rx = 8'h00;
      @(negedge clk);
      cs = 1'b0;
      #HALF;
      for (int i = 0; i < nbits; i++) begin
         mosi = (i < 8) ? cmd[7-i] : (i < 16) ? wd[15-i] : 1'b0;
         #HALF;
         sclk = 1'b1;
         if (i >= 8 && i < 16) last_rx[15-i] = miso;
         if (i >= 16) check("miso_after_16", {31'd0, miso}, 32'd0);
         if (i == 4) check("busy_in_frame", {31'd0, busy}, 32'd1);
         #HALF;
         sclk = 1'b0;
      end
      #HALF;
      mosi = 1'b0;
      if (raise_cs) begin
         cs = 1'b1;
         #20;
         if (nbits >= 16) check("busy_between", {31'd0, busy}, 32'd0);
         #(gap_ns - 20);
      end
   endtask

   initial begin : monitor
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (wr_strobe) begin
               if (exp_q.size() == 0 || exp_q[0].kind != 0) check("unexpected_wr_strobe", 32'd1, 32'd0);
               else begin
                  mon_e = exp_q.pop_front();
                  check("wr_addr", {30'd0, wr_addr}, {30'd0, mon_e.addr});
               end
            end
            if (frame_err) begin
               if (exp_q.size() == 0 || exp_q[0].kind != 2) check("unexpected_frame_err", 32'd1, 32'd0);
               else begin
                  mon_e = exp_q.pop_front();
                  check("frame_err", 32'd1, 32'd1 - {31'd0, frame_done});
               end
            end
            if (frame_done) begin
               if (exp_q.size() == 0 || exp_q[0].kind != 1) check("unexpected_frame_done", 32'd1, 32'd0);
               else begin
                  mon_e = exp_q.pop_front();
                  if (mon_e.is_read) check("read_data", {24'd0, last_rx}, {24'd0, mon_e.data});
                  @(negedge clk);
                  check("reg_out", reg_out, mon_e.regs);
               end
            end
         end
      end
   end

   initial begin : watchdog
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "timeout");
   end

   initial begin : stim
      logic [7:0] rc, rw;
      int         r, nb;
      model_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_miso",       {31'd0, miso},       32'd0);
      check("rst_busy",       {31'd0, busy},       32'd0);
      check("rst_wr_strobe",  {31'd0, wr_strobe},  32'd0);
      check("rst_frame_done", {31'd0, frame_done}, 32'd0);
      check("rst_frame_err",  {31'd0, frame_err},  32'd0);
      check("rst_wr_addr",    {30'd0, wr_addr},    32'd0);
      check("rst_reg_out",    reg_out,             flat());
      rst = 1'b0;
      repeat (10) @(negedge clk);

      // write addr1 then read it back
      frame(8'h81, 8'h3C, 16, 1'b1, 200);
      frame(8'h01, 8'h00, 16, 1'b1, 200);
      // ID register reads and ignores writes
      frame(8'h00, 8'h00, 16, 1'b1, 200);
      frame(8'h80, 8'hFF, 16, 1'b1, 200);
      frame(8'h00, 8'h00, 16, 1'b1, 200);
      // truncated write
      frame(8'h82, 8'h55, 12, 1'b1, 200);
      frame(8'h02, 8'h00, 16, 1'b1, 200);
      // over-long read window
      frame(8'h01, 8'h00, 20, 1'b1, 200);
      // back-to-back writes with a 4-cycle cs gap
      frame(8'h82, 8'h11, 16, 1'b1, 40);
      frame(8'h83, 8'h22, 16, 1'b1, 200);
      frame(8'h03, 8'h00, 16, 1'b1, 200);

      // reset in the middle of a write with cs held low
      frame(8'h83, 8'h5E, 11, 1'b0, 0);
      @(negedge clk);
      rst = 1'b1;
      model_reset();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (6) @(negedge clk);
      check("wait_cs_busy", {31'd0, busy}, 32'd0);
      for (int i = 0; i < 4; i++) begin
         #HALF; sclk = 1'b1;
         #HALF; sclk = 1'b0;
      end
      #HALF;
      cs = 1'b1;
      repeat (10) @(negedge clk);
      check("reg_out_after_reset", reg_out, flat());
      frame(8'h83, 8'h9A, 16, 1'b1, 200);
      frame(8'h03, 8'h00, 16, 1'b1, 200);

      // randomized frames
      for (int k = 0; k < 30; k++) begin
         rc = 8'($urandom);
         rw = 8'($urandom);
         r  = int'($urandom_range(0, 9));
         nb = (r < 6) ? 16 : (r < 8) ? int'($urandom_range(1, 15)) : int'($urandom_range(17, 20));
         frame(rc, rw, nb, 1'b1, 10 * int'($urandom_range(4, 30)));
      end

      for (int t = 0; t < 200 && exp_q.size() > 0; t++) @(negedge clk);
      while (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         check("missing_event_kind", 32'hFFFF_FFFF, mon_e.kind);
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/spi_slave_regs.md
Name: spi_slave_regs

Overview:
SPI mode-0 slave that sits downstream of spi_master on the sclk/cs/mosi/miso bus. It consumes the master's serial frames and returns read data on miso. It exposes a small register file: address 0 is a read-only ID, addresses 1..3 are read/write. All logic runs on the system clock; the SPI pins are oversampled, not used as clocks.

Parameters:
DATA_W, 8, register and data-byte width in bits
NUM_REGS, 4, register count; address width is 2
ID_VALUE, 8'hA5, read-only contents of address 0
REG_RESET, 8'h00, reset value of registers 1..3

Ports:
clk  in  1  system clock; sclk must be at most clk/4
rst  in  1  synchronous, active-high reset
sclk  in  1  SPI clock from master, asynchronous to clk, idle low
cs  in  1  chip select from master, active low, asynchronous
mosi  in  1  serial data from master, asynchronous
miso  out  1  serial data to master; 0 whenever not shifting read data
reg_out  out  NUM_REGS*DATA_W  flattened register file; reg i at bits [i*8 +: 8]; slice 0 = ID_VALUE
wr_strobe  out  1  one-cycle pulse when a write commits to registers 1..3
wr_addr  out  2  address of the last committed write; valid with wr_strobe
frame_done  out  1  one-cycle pulse when a 16-bit frame completes
frame_err  out  1  one-cycle pulse when cs rises after 1..15 bits
busy  out  1  high while in CMD or DATA state

Behaviour:
- Input sync: sclk, cs and mosi each pass through a 2-flop synchronizer.
  - Edges are detected on the synchronized signals: rise = sync & ~prev, fall = ~sync & prev.
  - Edge latency is 3 clk cycles from the pin.
- Frame format, MSB first, 16 bits:
  - Command byte: bit7 = 1 for write, 0 for read; bits6:2 ignored; bits1:0 = address.
  - Data byte: write data from master, or read data to master.
- Sampling: mosi is sampled on sclk rise. miso is updated on sclk fall.
- States:
  - IDLE: waiting for cs fall.
  - CMD: shifting in the command byte.
  - DATA: shifting the data byte.
  - TAIL: 16 bits done, waiting for cs high.
  - WAIT_CS: cs was low at reset exit.
- Transitions:
  - IDLE -> CMD on cs fall. The bit counter clears to 0.
  - CMD -> DATA on the 8th sclk rise.
    - The command is latched.
    - For a read, the shift-out register loads reg[addr].
    - Its MSB drives miso on the following sclk fall (the 8th fall).
  - DATA -> TAIL on the 16th sclk rise.
    - Write to addr 1..3: the register is updated and wr_strobe/wr_addr pulse in the same cycle.
    - Write to addr 0: no register change and no wr_strobe.
    - frame_done pulses.
  - TAIL: further sclk edges are ignored and miso = 0. Go to IDLE on cs rise.
  - Any of CMD/DATA: cs rise returns to IDLE and pulses frame_err. No register changes; a write needs all 16 bits.
  - A cs rise exactly after the 16th rise is a normal frame_done, not frame_err.
- Reads:
  - miso shifts the data MSB-first on falls 8..15.
  - The master samples on rises 9..16.
  - miso = 0 in IDLE, CMD, TAIL and WAIT_CS.
- Simultaneity: if a synchronized cs rise and an sclk edge fall in the same cycle, cs wins and the sclk edge is dropped.
- Reset (rst = 1 at a clk edge):
  - Outputs:
    - miso = 0.
    - wr_strobe, frame_done, frame_err, busy = 0.
    - wr_addr = 0.
  - Registers 1..3 = REG_RESET.
  - Synchronizers are cleared to idle values (sclk 0, cs 1).
- Reset exit:
  - If synchronized cs is low on leaving reset, enter WAIT_CS and ignore everything until cs rises, then go to IDLE.
  - A frame interrupted by reset is never completed.
- reg_out is registered and reflects a write on the cycle after wr_strobe.

Test Plan:
1. Write 0x81, 0x3C (write addr1) -> wr_strobe with wr_addr = 1, frame_done, reg_out[15:8] = 8'h3C. Then read 0x01, 0x00 -> miso shifts 0,0,1,1,1,1,0,0.
2. Read addr0 (0x00, 0x00) after reset -> master receives 8'hA5. Write 0x80, 0xFF -> no wr_strobe, addr0 still reads 8'hA5, frame_done pulses.
3. Write 0x82, 0x55 with cs raised after 12 bits -> frame_err pulses once, no frame_done, reg2 stays 8'h00.
4. Assert rst during DATA of a write to addr3 with cs still low, keep cs low 4 more sclk cycles, then raise it -> regs = REG_RESET, state passes WAIT_CS -> IDLE. Next full write 0x83, 0x9A -> reg3 = 8'h9A.
5. Read addr1 = 0x3C with 20 sclk pulses in one cs window -> correct 8 bits, miso = 0 for pulses 17..20, single frame_done, no frame_err.
6. Back-to-back frames with cs high for 4 clk cycles between writes to addr2 (0x11) and addr3 (0x22) -> both commit with two wr_strobe pulses; busy low between frames.
